// File: rtl/acc_prog_sequencer_if.sv
// Host-to-sequencer program word stream (valid/ready, one 12-bit instruction per beat).
interface acc_prog_sequencer_if;
    logic        wr_valid;
    logic        wr_ready;
    logic [11:0] wr_data;
    logic        wr_last;

    modport master (output wr_valid, output wr_data, output wr_last, input wr_ready);
    modport slave  (input wr_valid, input wr_data, input wr_last, output wr_ready);
endinterface

// File: rtl/acc_prog_sequencer.sv
// Loads a program into the accumulator CPU, runs it and captures AC when the PC passes the HALT.
// Optional RUN watchdog: define ACC_SEQ_WDOG_EN.
module acc_prog_sequencer #(
    parameter int MEM_DEPTH   = 10,
    parameter int WDOG_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_start,
    acc_prog_sequencer_if.slave   wr,
    output logic                  cpu_reset,
    output logic                  cpu_we,
    output logic [3:0]            cpu_addr,
    output logic [11:0]           cpu_instr,
    input  logic [3:0]            cpu_pc,
    input  logic [7:0]            cpu_ac,
    output logic                  busy,
    output logic                  done,
    output logic [7:0]            result,
    output logic                  err,
    output logic                  timeout
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_APPEND, S_RUN, S_DONE} state_t;

    state_t      state_q;
    logic [3:0]  cnt_q, stop_pc_q, cpu_addr_q;
    logic        halt_seen_q, cpu_reset_q, cpu_we_q, wr_ready_q, busy_q, done_q, err_q;
    logic [11:0] cpu_instr_q;
    logic [7:0]  result_q;

    logic       beat, is_halt, halt_any, at_end, load_err;
    logic [3:0] cnt_inc;

    assign beat     = wr.wr_valid & wr_ready_q;
    assign is_halt  = (wr.wr_data[11:8] == 4'hA);
    assign halt_any = halt_seen_q | is_halt;
    assign at_end   = (cnt_q == 4'(MEM_DEPTH - 1));
    assign cnt_inc  = cnt_q + 4'd1;
    // A beat in the last slot is fatal unless it closes a program that already has its HALT.
    assign load_err = beat & at_end & ~(wr.wr_last & halt_any);

`ifdef ACC_SEQ_WDOG_EN
    logic [15:0] wdog_q;
    logic        timeout_q;
    assign timeout = timeout_q;
`else
    logic unused_wdog;
    assign unused_wdog = (WDOG_CYCLES != 0);
    assign timeout     = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            stop_pc_q   <= '0;
            halt_seen_q <= 1'b0;
            cpu_reset_q <= 1'b1;
            cpu_we_q    <= 1'b0;
            cpu_addr_q  <= '0;
            cpu_instr_q <= '0;
            wr_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= '0;
            err_q       <= 1'b0;
`ifdef ACC_SEQ_WDOG_EN
            wdog_q      <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    cpu_we_q <= 1'b0;
                    if (load_start) begin
                        state_q     <= S_LOAD;
                        done_q      <= 1'b0;
                        err_q       <= 1'b0;
                        cnt_q       <= '0;
                        halt_seen_q <= 1'b0;
                        cpu_reset_q <= 1'b0;
                        wr_ready_q  <= 1'b1;
                        busy_q      <= 1'b1;
`ifdef ACC_SEQ_WDOG_EN
                        timeout_q   <= 1'b0;
                        wdog_q      <= '0;
`endif
                    end
                end
                S_LOAD: begin
                    cpu_we_q <= 1'b0;
                    if (load_err) begin
                        // The offending word is dropped: writing it would overlap cpu_reset.
                        state_q     <= S_DONE;
                        err_q       <= 1'b1;
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        cpu_reset_q <= 1'b1;
                        wr_ready_q  <= 1'b0;
                    end else if (beat) begin
                        cpu_we_q    <= 1'b1;
                        cpu_addr_q  <= cnt_q;
                        cpu_instr_q <= wr.wr_data;
                        cnt_q       <= cnt_inc;
                        if (is_halt && !halt_seen_q) begin
                            halt_seen_q <= 1'b1;
                            stop_pc_q   <= cnt_inc;
                        end
                        if (wr.wr_last) begin
                            wr_ready_q <= 1'b0;
                            state_q    <= halt_any ? S_RUN : S_APPEND;
                        end
                    end
                end
                S_APPEND: begin
                    cpu_we_q    <= 1'b1;
                    cpu_addr_q  <= cnt_q;
                    cpu_instr_q <= 12'hA00;
                    stop_pc_q   <= cnt_inc;
                    state_q     <= S_RUN;
                end
                S_RUN: begin
                    cpu_we_q <= 1'b0;
                    // While the final write is still on the port the CPU has not restarted from 0.
                    if (!cpu_we_q && cpu_pc == stop_pc_q) begin
                        result_q    <= cpu_ac;
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        cpu_reset_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
`ifdef ACC_SEQ_WDOG_EN
                    else if (wdog_q == 16'(WDOG_CYCLES - 1)) begin
                        result_q    <= cpu_ac;
                        timeout_q   <= 1'b1;
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        cpu_reset_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        wdog_q <= wdog_q + 16'd1;
                    end
`endif
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign wr.wr_ready = wr_ready_q;
    assign cpu_reset   = cpu_reset_q;
    assign cpu_we      = cpu_we_q;
    assign cpu_addr    = cpu_addr_q;
    assign cpu_instr   = cpu_instr_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign result      = result_q;
    assign err         = err_q;
endmodule

// File: tb/tb_acc_prog_sequencer.sv
// Scoreboard bench for acc_prog_sequencer with a small behavioural accumulator CPU.
module tb_acc_prog_sequencer;
`ifdef ACC_SEQ_WDOG_EN
    localparam int WD = 8;
`else
    localparam int WD = 64;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_start = 1'b0;
    logic        cpu_reset, cpu_we, busy, done, err, timeout;
    logic [3:0]  cpu_addr, cpu_pc;
    logic [11:0] cpu_instr;
    logic [7:0]  cpu_ac, result;

    always #5 clk = ~clk;

    acc_prog_sequencer_if wr_if ();

    acc_prog_sequencer #(.MEM_DEPTH(10), .WDOG_CYCLES(WD)) u_dut (
        .clk(clk), .reset(reset), .load_start(load_start), .wr(wr_if.slave),
        .cpu_reset(cpu_reset), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_instr(cpu_instr),
        .cpu_pc(cpu_pc), .cpu_ac(cpu_ac), .busy(busy), .done(done), .result(result),
        .err(err), .timeout(timeout)
    );

    // CPU model: 1/2 add imm, 3 load imm, 7 invert, A halt; 3 cycles per instruction.
    // It restarts from PC 0 while held in reset or while its memory is being written.
    logic [11:0] mem [16];
    logic [3:0]  pc;
    logic [7:0]  ac;
    int          ph;
    logic        halted;
    assign cpu_pc = pc;
    assign cpu_ac = ac;

    always @(posedge clk) begin
        if (cpu_we) mem[cpu_addr] <= cpu_instr;
        if (cpu_reset || cpu_we) begin
            pc <= 4'd0; ac <= 8'd0; ph <= 0; halted <= 1'b0;
        end else if (!halted) begin
            if (ph == 2) begin
                ph <= 0;
                pc <= pc + 4'd1;
                case (mem[pc][11:8])
                    4'h1, 4'h2: ac <= ac + mem[pc][7:0];
                    4'h3:       ac <= mem[pc][7:0];
                    4'h7:       ac <= ~ac;
                    4'hA:       halted <= 1'b1;
                    default:    ;
                endcase
            end else begin
                ph <= ph + 1;
            end
        end
    end

    typedef struct { logic [7:0] res; logic err; logic to; bit chk_res; } exp_t;
    typedef struct { logic [3:0] a; logic [11:0] d; } wr_t;
    exp_t exp_q[$];
    wr_t  wq[$];
    int   checks = 0;
    int   errors = 0;
    logic [7:0] last_res = 8'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    // Completion monitor
    logic done_d = 1'b0;
    always @(negedge clk) begin
        if (done && !done_d) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done actual 1 required 0");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("done_err", 32'(err), 32'(e.err));
                chk("done_timeout", 32'(timeout), 32'(e.to));
                chk("done_busy", 32'(busy), 32'd0);
                chk("done_cpu_reset", 32'(cpu_reset), 32'd1);
                if (e.chk_res) chk("done_result", 32'(result), 32'(e.res));
            end
        end
        done_d = done;
    end

    // Write-port monitor
    always @(negedge clk) begin
        if (cpu_we) begin
            if (wq.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_write actual %0h@%0h required none", cpu_instr, cpu_addr);
            end else begin
                wr_t w;
                w = wq.pop_front();
                chk("write_addr", 32'(cpu_addr), 32'(w.a));
                chk("write_data", 32'(cpu_instr), 32'(w.d));
            end
            chk("we_with_reset", 32'(cpu_reset), 32'd0);
        end
    end

    task automatic start_load();
        @(negedge clk); load_start = 1'b1;
        @(negedge clk); load_start = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the beat is accepted.
    task automatic send(input logic [11:0] d, input logic last, input logic [3:0] a, input bit push);
        int k;
        wr_if.wr_valid = 1'b1; wr_if.wr_data = d; wr_if.wr_last = last;
        k = 0;
        while (!wr_if.wr_ready && k < 50) begin @(negedge clk); k++; end
        if (!wr_if.wr_ready) chk("send_ready", 32'(wr_if.wr_ready), 32'd1);
        if (push) wq.push_back('{a: a, d: d});
        @(negedge clk);
        wr_if.wr_valid = 1'b0; wr_if.wr_last = 1'b0;
    endtask

    task automatic expect_done(input logic [7:0] r, input logic e, input logic t, input bit cr);
        exp_q.push_back('{res: r, err: e, to: t, chk_res: cr});
    endtask

    task automatic wait_done(input string n);
        int k;
        k = 0;
        while (!done && k < 400) begin @(negedge clk); k++; end
        chk(n, 32'(done), 32'd1);
        @(negedge clk);
    endtask

    task automatic check_reset_vals(input string n);
        chk({n, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
        chk({n, "_cpu_we"}, 32'(cpu_we), 32'd0);
        chk({n, "_cpu_addr"}, 32'(cpu_addr), 32'd0);
        chk({n, "_cpu_instr"}, 32'(cpu_instr), 32'd0);
        chk({n, "_wr_ready"}, 32'(wr_if.wr_ready), 32'd0);
        chk({n, "_busy"}, 32'(busy), 32'd0);
        chk({n, "_done"}, 32'(done), 32'd0);
        chk({n, "_result"}, 32'(result), 32'd0);
        chk({n, "_err"}, 32'(err), 32'd0);
        chk({n, "_timeout"}, 32'(timeout), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual expired required finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        wr_if.wr_valid = 1'b0; wr_if.wr_data = 12'h000; wr_if.wr_last = 1'b0;
        @(negedge clk);
        check_reset_vals("rst");
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        chk("idle_cpu_reset", 32'(cpu_reset), 32'd1);

`ifdef ACC_SEQ_WDOG_EN
        // Watchdog: HALT at address 5 is far beyond an 8-cycle budget
        start_load();
        for (int i = 0; i < 5; i++) send(12'h101, 1'b0, 4'(i), 1'b1);
        send(12'hA00, 1'b1, 4'd5, 1'b1);
        expect_done(8'h00, 1'b0, 1'b1, 1'b0);
        wait_done("wdog_done");
        chk("wdog_timeout_level", 32'(timeout), 32'd1);
`else
        // Plain program with explicit HALT
        start_load();
        send(12'h105, 1'b0, 4'd0, 1'b1);
        send(12'h203, 1'b0, 4'd1, 1'b1);
        send(12'hA00, 1'b1, 4'd2, 1'b1);
        expect_done(8'h08, 1'b0, 1'b0, 1'b1);
        wait_done("t1_done");

        // No HALT: sequencer appends one at address 2
        start_load();
        send(12'h1F0, 1'b0, 4'd0, 1'b1);
        send(12'h700, 1'b1, 4'd1, 1'b1);
        wq.push_back('{a: 4'd2, d: 12'hA00});
        expect_done(8'h0F, 1'b0, 1'b0, 1'b1);
        wait_done("t2_done");

        // Stalled beats, then wr_valid toggling during RUN must not write
        start_load();
        send(12'h1AA, 1'b0, 4'd0, 1'b1);
        repeat (3) @(negedge clk);
        send(12'h355, 1'b0, 4'd1, 1'b1);
        repeat (2) @(negedge clk);
        send(12'hA00, 1'b1, 4'd2, 1'b1);
        for (int i = 0; i < 6; i++) begin
            wr_if.wr_valid = ~wr_if.wr_valid; wr_if.wr_data = 12'hFFF;
            @(negedge clk);
        end
        wr_if.wr_valid = 1'b0;
        expect_done(8'h55, 1'b0, 1'b0, 1'b1);
        wait_done("t3_done");
        last_res = 8'h55;

        // Overflow with wr_last on the 10th word: error, result held
        start_load();
        for (int i = 0; i < 10; i++) send(12'h101, i == 9, 4'(i), i < 9);
        expect_done(last_res, 1'b1, 1'b0, 1'b1);
        wait_done("t4_done");

        // Overflow without wr_last: wr_ready drops in the following cycle
        start_load();
        for (int i = 0; i < 10; i++) send(12'h102, 1'b0, 4'(i), i < 9);
        chk("t5_ready_drop", 32'(wr_if.wr_ready), 32'd0);
        expect_done(last_res, 1'b1, 1'b0, 1'b1);
        wait_done("t5_done");

        // Async reset mid-RUN, then a fresh load
        start_load();
        for (int i = 0; i < 5; i++) send(12'h101, 1'b0, 4'(i), 1'b1);
        send(12'hA00, 1'b1, 4'd5, 1'b1);
        repeat (4) @(negedge clk);
        chk("t6_busy_before_reset", 32'(busy), 32'd1);
        #1 reset = 1'b1;
        #1 check_reset_vals("t6");
        @(negedge clk); reset = 1'b0;
        start_load();
        send(12'h142, 1'b0, 4'd0, 1'b1);
        send(12'hA00, 1'b1, 4'd1, 1'b1);
        expect_done(8'h42, 1'b0, 1'b0, 1'b1);
        wait_done("t6_done");
`endif

        repeat (3) @(negedge clk);
        chk("exp_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("write_queue_empty", 32'(wq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
